// File: rtl/qqspi_psram_responder.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// qqspi_psram_responder
// SPI/QSPI target that behaves like a PSRAM-style serial memory. It is fully
// synchronous to clk. cen, sclk and sio_i are oversampled through synchroniser
// flops, and all sampling and driving keys off the detected sclk edges.
// Opcodes: 0x03 read, 0x02 write, 0xEB quad read (6 wait clocks), 0x38 quad
// write. Any other opcode is ignored until cen rises.
//
// Parameters
//   MEM_AW      byte-address width of the internal RAM (2^MEM_AW bytes)
//   SYNC_STAGES synchroniser depth on cen/sclk/sio_i (>= 2)
//
// Ports
//   clk, resetn     system clock (>= 8x sclk), synchronous active-low reset
//   cen, sclk       chip enable (active low) and mode-0 serial clock
//   sio_i[3:0]      {sio3,sio2,sio1,sio0} from the initiator
//   sio_o, sio_oe   output data and per-lane output enable
//   busy            synchronised cen inverted, registered
//   wr_count[15:0]  wrapping count of bytes written over SPI
//
// Optional build macro QQSPI_RESPONDER_BACKDOOR_EN adds a host-side RAM port
// (bd_valid/bd_we/bd_addr/bd_wdata in, bd_rdata/bd_ready out). It is served
// only while the FSM is idle. Without the macro the RAM is SPI-only.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | cen high; counters cleared, backdoor may access RAM
// S_CMD    | shifting the 8-bit opcode, single-bit
// S_ADDR   | shifting 24 address bits (24 single or 6 quad rises)
// S_WAIT   | 6 dummy rises before quad read data, outputs off
// S_RDATA  | streaming mem[ptr..] out on sclk falls
// S_WDATA  | assembling bytes on sclk rises and writing mem[ptr..]
// S_IGNORE | unknown opcode; do nothing until cen rises
// ---------------------------------------------------------------------------
module qqspi_psram_responder #(
    parameter int MEM_AW      = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cen,
    input  logic              sclk,
    input  logic [3:0]        sio_i,
    output logic [3:0]        sio_o,
    output logic [3:0]        sio_oe,
    output logic              busy,
    output logic [15:0]       wr_count
`ifdef QQSPI_RESPONDER_BACKDOOR_EN
    ,
    input  logic              bd_valid,
    input  logic              bd_we,
    input  logic [MEM_AW-1:0] bd_addr,
    input  logic [7:0]        bd_wdata,
    output logic [7:0]        bd_rdata,
    output logic              bd_ready
`endif
);

    localparam logic [7:0] OP_READ   = 8'h03;
    localparam logic [7:0] OP_WRITE  = 8'h02;
    localparam logic [7:0] OP_QREAD  = 8'hEB;
    localparam logic [7:0] OP_QWRITE = 8'h38;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_WAIT, S_RDATA, S_WDATA, S_IGNORE
    } state_t;

    state_t r_state, w_state_next;

    logic [SYNC_STAGES-1:0]      r_cen_sync;
    logic [SYNC_STAGES-1:0]      r_sclk_sync;
    logic [SYNC_STAGES-1:0][3:0] r_sio_sync;
    logic                        r_sclk_d;
    logic                        w_cen_s, w_sclk_s, w_rise, w_fall, w_last;
    logic [3:0]                  w_sio_s;

    logic [4:0]        r_cnt;
    logic [23:0]       r_shift;
    logic [23:0]       w_shift_next;
    logic [7:0]        r_cmd;
    logic              r_quad;
    logic [MEM_AW-1:0] r_ptr;
    logic [7:0]        r_out_sh;
    logic [3:0]        r_sio_o;
    logic              r_busy;
    logic [15:0]       r_wr_count;
    logic [7:0]        r_rd_data;
    logic [MEM_AW-1:0] w_rd_addr;
    logic              w_spi_we;

    logic [7:0] r_mem [2**MEM_AW];

    // Synchronisers; cen resets high so busy does not glitch out of reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cen_sync  <= '1;
            r_sclk_sync <= '0;
            r_sio_sync  <= '0;
            r_sclk_d    <= 1'b0;
        end else begin
            r_cen_sync  <= {r_cen_sync[SYNC_STAGES-2:0], cen};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_sio_sync  <= {r_sio_sync[SYNC_STAGES-2:0], sio_i};
            r_sclk_d    <= w_sclk_s;
        end
    end

    assign w_cen_s  = r_cen_sync[SYNC_STAGES-1];
    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_sio_s  = r_sio_sync[SYNC_STAGES-1];
    // A cen rise wins over an sclk edge seen in the same clk.
    assign w_rise   =  w_sclk_s & ~r_sclk_d & ~w_cen_s;
    assign w_fall   = ~w_sclk_s &  r_sclk_d & ~w_cen_s;

    assign w_shift_next = r_quad ? {r_shift[19:0], w_sio_s}
                                 : {r_shift[22:0], w_sio_s[0]};

    // Last bit/nibble of the current field.
    always_comb begin
        w_last = 1'b0;
        case (r_state)
            S_CMD:            w_last = (r_cnt == 5'd7);
            S_ADDR:           w_last = r_quad ? (r_cnt == 5'd5) : (r_cnt == 5'd23);
            S_WAIT:           w_last = (r_cnt == 5'd5);
            S_RDATA, S_WDATA: w_last = r_quad ? (r_cnt == 5'd1) : (r_cnt == 5'd7);
            default:          w_last = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (r_state != S_IDLE && w_cen_s) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (!w_cen_s) w_state_next = S_CMD;
                S_CMD:
                    if (w_rise && w_last) begin
                        case (w_shift_next[7:0])
                            OP_READ, OP_WRITE, OP_QREAD, OP_QWRITE: w_state_next = S_ADDR;
                            default:                                w_state_next = S_IGNORE;
                        endcase
                    end
                S_ADDR:
                    if (w_rise && w_last) begin
                        case (r_cmd)
                            OP_READ:  w_state_next = S_RDATA;
                            OP_QREAD: w_state_next = S_WAIT;
                            default:  w_state_next = S_WDATA;
                        endcase
                    end
                S_WAIT:   if (w_rise && w_last) w_state_next = S_RDATA;
                default:  w_state_next = r_state;
            endcase
        end
    end

    always_comb begin
        sio_oe = 4'b0000;
        sio_o  = 4'b0000;
        if (r_state == S_RDATA) begin
            sio_oe = r_quad ? 4'b1111 : 4'b0010;
            sio_o  = r_sio_o;
        end
        busy     = r_busy;
        wr_count = r_wr_count;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt      <= '0;
            r_shift    <= '0;
            r_cmd      <= '0;
            r_quad     <= 1'b0;
            r_ptr      <= '0;
            r_out_sh   <= '0;
            r_sio_o    <= '0;
            r_busy     <= 1'b0;
            r_wr_count <= '0;
        end else begin
            r_busy <= ~w_cen_s;
            case (r_state)
                S_IDLE: begin
                    r_cnt   <= '0;
                    r_shift <= '0;
                    r_quad  <= 1'b0;
                    r_sio_o <= '0;
                end
                S_CMD, S_ADDR, S_WAIT, S_WDATA: begin
                    if (w_rise) begin
                        r_shift <= w_shift_next;
                        r_cnt   <= w_last ? 5'd0 : r_cnt + 5'd1;
                        if (w_last && r_state == S_CMD) begin
                            r_cmd  <= w_shift_next[7:0];
                            r_quad <= (w_shift_next[7:0] == OP_QREAD) ||
                                      (w_shift_next[7:0] == OP_QWRITE);
                        end
                        // ptr is loaded here; the registered RAM read picks it up next clk.
                        if (w_last && r_state == S_ADDR) r_ptr <= w_shift_next[MEM_AW-1:0];
                        if (w_last && r_state == S_WDATA) begin
                            r_ptr      <= r_ptr + 1'b1;
                            r_wr_count <= r_wr_count + 16'd1;
                        end
                    end
                end
                S_RDATA: begin
                    if (w_fall) begin
                        // cnt==0 starts a byte from the prefetched RAM word.
                        if (r_cnt == 5'd0) begin
                            if (r_quad) begin
                                r_sio_o  <= r_rd_data[7:4];
                                r_out_sh <= {r_rd_data[3:0], 4'b0000};
                            end else begin
                                r_sio_o  <= {2'b00, r_rd_data[7], 1'b0};
                                r_out_sh <= {r_rd_data[6:0], 1'b0};
                            end
                        end else begin
                            if (r_quad) begin
                                r_sio_o  <= r_out_sh[7:4];
                                r_out_sh <= {r_out_sh[3:0], 4'b0000};
                            end else begin
                                r_sio_o  <= {2'b00, r_out_sh[7], 1'b0};
                                r_out_sh <= {r_out_sh[6:0], 1'b0};
                            end
                        end
                        r_cnt <= w_last ? 5'd0 : r_cnt + 5'd1;
                        if (w_last) r_ptr <= r_ptr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_spi_we = (r_state == S_WDATA) && w_rise && w_last;

`ifdef QQSPI_RESPONDER_BACKDOOR_EN
    logic r_bd_ready;
    logic w_bd_go;

    // Served only in IDLE, so SPI traffic always owns the RAM when active.
    assign w_bd_go   = bd_valid && (r_state == S_IDLE) && !r_bd_ready;
    assign w_rd_addr = (r_state == S_IDLE) ? bd_addr : r_ptr;
    assign bd_rdata  = r_rd_data;
    assign bd_ready  = r_bd_ready;

    always_ff @(posedge clk) begin
        if (!resetn) r_bd_ready <= 1'b0;
        else         r_bd_ready <= w_bd_go;
    end

    always_ff @(posedge clk) begin
        if (w_spi_we)              r_mem[r_ptr]   <= w_shift_next[7:0];
        else if (w_bd_go && bd_we) r_mem[bd_addr] <= bd_wdata;
        r_rd_data <= r_mem[w_rd_addr];
    end
`else
    assign w_rd_addr = r_ptr;

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_spi_we) r_mem[r_ptr] <= w_shift_next[7:0];
        r_rd_data <= r_mem[w_rd_addr];
    end
`endif

endmodule

// File: tb/tb_qqspi_psram_responder.sv
`timescale 1ns/1ps
module tb_qqspi_psram_responder;

    localparam int MEM_AW = 10;
    localparam int MEM_SZ = 1 << MEM_AW;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cen = 1'b1;
    logic        sclk = 1'b0;
    logic [3:0]  sio_i = 4'h0;
    logic [3:0]  sio_o, sio_oe;
    logic        busy;
    logic [15:0] wr_count;

`ifdef QQSPI_RESPONDER_BACKDOOR_EN
    logic              bd_valid = 1'b0, bd_we = 1'b0, bd_ready;
    logic [MEM_AW-1:0] bd_addr = '0;
    logic [7:0]        bd_wdata = '0, bd_rdata;
`endif

    always #5 clk = ~clk;

    qqspi_psram_responder #(.MEM_AW(MEM_AW), .SYNC_STAGES(2)) dut (
        .clk(clk), .resetn(resetn), .cen(cen), .sclk(sclk), .sio_i(sio_i),
        .sio_o(sio_o), .sio_oe(sio_oe), .busy(busy), .wr_count(wr_count)
`ifdef QQSPI_RESPONDER_BACKDOOR_EN
        , .bd_valid(bd_valid), .bd_we(bd_we), .bd_addr(bd_addr),
        .bd_wdata(bd_wdata), .bd_rdata(bd_rdata), .bd_ready(bd_ready)
`endif
    );

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] oe;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] ref_mem [MEM_SZ];
    int         ref_wr = 0;
    int         checks = 0;
    int         failures = 0;
    bit         quiet = 1'b0;
    int         quiet_viol = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Output enable must stay off whenever the bench expects a silent bus.
    always @(negedge clk) if (quiet && sio_oe !== 4'b0000) quiet_viol++;

    // Monitor: assemble driven bits at each sclk rise and score whole bytes.
    logic [7:0] mon_byte = '0;
    int         mon_bits = 0;
    bit         mon_oe_bad = 1'b0;
    always @(posedge sclk) begin
        if (sio_oe !== 4'b0000) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_drive", 32'(sio_oe), 32'h0);
            end else begin
                if (sio_oe !== exp_q[0].oe) mon_oe_bad = 1'b1;
                if (exp_q[0].oe == 4'hF) begin
                    mon_byte = {mon_byte[3:0], sio_o};
                    mon_bits += 4;
                end else begin
                    mon_byte = {mon_byte[6:0], sio_o[1]};
                    mon_bits += 1;
                end
                if (mon_bits >= 8) begin
                    chk("read_byte", 32'(mon_byte), 32'(exp_q[0].data));
                    chk("read_oe", 32'(mon_oe_bad), 32'h0);
                    void'(exp_q.pop_front());
                    mon_bits   = 0;
                    mon_oe_bad = 1'b0;
                end
            end
        end
    end

    task automatic half();
        repeat (8) @(negedge clk);
    endtask

    task automatic rise_q(input logic [3:0] v, input bit clr);
        sio_i = v;
        half();
        if (clr) quiet = 1'b0;
        sclk = 1'b1;
        half();
        sclk = 1'b0;
    endtask

    task automatic send(input logic [23:0] val, input int units, input bit quad, input bit clr_last);
        for (int i = units - 1; i >= 0; i--) begin
            logic [3:0] v;
            v = quad ? val[4*i +: 4] : {3'b000, val[i]};
            rise_q(v, clr_last && (i == 0));
        end
    endtask

    task automatic begin_txn();
        quiet = 1'b1;
        cen = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic end_txn();
        repeat (4) @(negedge clk);
        cen = 1'b1;
        repeat (8) @(negedge clk);
        quiet = 1'b0;
    endtask

    // data holds the bytes MSB-first: byte 0 is data[8*n-1 -: 8].
    task automatic spi_write(input bit quad, input logic [23:0] addr, input logic [63:0] data, input int n);
        begin_txn();
        send(quad ? 24'h38 : 24'h02, 8, 1'b0, 1'b0);
        chk("busy_active", 32'(busy), 32'h1);
        send(addr, quad ? 6 : 24, quad, 1'b0);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = data[8*(n-1-i) +: 8];
            send({16'h0, b}, quad ? 2 : 8, quad, 1'b0);
            ref_mem[(int'(addr) + i) % MEM_SZ] = b;
            ref_wr++;
        end
        end_txn();
        chk("wr_count", 32'(wr_count), 32'(ref_wr & 16'hFFFF));
    endtask

    task automatic spi_read(input bit quad, input logic [23:0] addr, input int n);
        begin_txn();
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.data = ref_mem[(int'(addr) + i) % MEM_SZ];
            e.oe   = quad ? 4'hF : 4'h2;
            exp_q.push_back(e);
        end
        send(quad ? 24'hEB : 24'h03, 8, 1'b0, 1'b0);
        if (quad) begin
            send(addr, 6, 1'b1, 1'b0);
            for (int k = 0; k < 6; k++) rise_q(4'($urandom), k == 5);
        end else begin
            send(addr, 24, 1'b0, 1'b1);
        end
        for (int i = 0; i < n * (quad ? 2 : 8); i++) rise_q(4'h0, 1'b0);
        end_txn();
        chk("read_drained", 32'(exp_q.size()), 32'h0);
        exp_q.delete();
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (5) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_sio_o", 32'(sio_o), 32'h0);
        chk("rst_sio_oe", 32'(sio_oe), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_wr_count", 32'(wr_count), 32'h0);

        // Single-mode write then read.
        spi_write(1'b0, 24'h000010, 64'hDEADBEEF, 4);
        spi_read(1'b0, 24'h000010, 4);
        chk("wr_count_4", 32'(wr_count), 32'd4);

        // Quad write then quad read with wait cycles.
        spi_write(1'b1, 24'h000020, 64'h12345678, 4);
        spi_read(1'b1, 24'h000020, 4);

        // Pointer wrap on write and read.
        spi_write(1'b0, 24'h0003FF, 64'hAABB, 2);
        spi_read(1'b0, 24'h000000, 1);
        spi_read(1'b0, 24'h0003FF, 2);

        // Abort mid-byte: the partial byte must never land.
        spi_write(1'b0, 24'h000040, 64'h3C, 1);
        begin_txn();
        send(24'h02, 8, 1'b0, 1'b0);
        send(24'h000040, 24, 1'b0, 1'b0);
        send(24'h00001F, 5, 1'b0, 1'b0);
        cen = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_wr_count", 32'(wr_count), 32'(ref_wr));
        repeat (4) @(negedge clk);
        quiet = 1'b0;
        spi_read(1'b1, 24'h000040, 1);

        // Unknown opcode: no drive, no writes.
        begin_txn();
        send(24'h9F, 8, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) rise_q(4'($urandom), 1'b0);
        end_txn();
        chk("unknown_wr_count", 32'(wr_count), 32'(ref_wr));
        chk("unknown_quiet", 32'(quiet_viol), 32'h0);
        spi_read(1'b0, 24'h000010, 4);

        // Reset mid-write: completed bytes stay in RAM, outputs clear.
        begin_txn();
        send(24'h02, 8, 1'b0, 1'b0);
        send(24'h000100, 24, 1'b0, 1'b0);
        send(24'h000011, 8, 1'b0, 1'b0);
        send(24'h000022, 8, 1'b0, 1'b0);
        send(24'h000005, 3, 1'b0, 1'b0);
        ref_mem[16'h100] = 8'h11;
        ref_mem[16'h101] = 8'h22;
        resetn = 1'b0;
        @(negedge clk);
        chk("rst_mid_oe", 32'(sio_oe), 32'h0);
        chk("rst_mid_sio_o", 32'(sio_o), 32'h0);
        chk("rst_mid_busy", 32'(busy), 32'h0);
        chk("rst_mid_wr_count", 32'(wr_count), 32'h0);
        resetn = 1'b1;
        cen = 1'b1;
        ref_wr = 0;
        repeat (8) @(negedge clk);
        quiet = 1'b0;
        spi_read(1'b0, 24'h000100, 2);

        // Initiator-style word sequence in both lane modes: sw, sb byte 1, lw.
        for (int q = 1; q >= 0; q--) begin
            logic [23:0] a;
            a = (q == 1) ? 24'h000200 : 24'h000210;
            spi_write(q[0], a, 64'h0DF0FECA, 4);
            spi_write(q[0], a + 24'd1, 64'h55, 1);
            chk("sb_merge", {ref_mem[int'(a)+3], ref_mem[int'(a)+2],
                             ref_mem[int'(a)+1], ref_mem[int'(a)]}, 32'hCAFE550D);
            spi_read(q[0], a, 4);
        end

        // Randomised bursts; reads stay inside the freshly written range.
        for (int it = 0; it < 10; it++) begin
            logic [23:0] a;
            int          n, off;
            a   = 24'($urandom);
            n   = $urandom_range(1, 6);
            off = $urandom_range(0, n - 1);
            spi_write(1'($urandom), a, {$urandom, $urandom}, n);
            spi_read(1'($urandom), a + 24'(off), n - off);
        end

        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        chk("quiet_total", 32'(quiet_viol), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
